fifo_rx: RTL
============

# fifo_rx

Frame-aware receive buffer for the Ethernet MAC. Sits between the MAC receive path (writer) and the host/user side (reader), the receive-direction counterpart of the transmit FIFO. Bytes of a frame are written speculatively and become visible to the reader only once the frame ends without error. Errored or overflowing frames are discarded in full by rewinding the write pointer.

## Interface
- `DATA_WIDTH`, 8: byte lane width.
- `FIFO_DEPTH`, 2048: storage entries; must be a power of 2, ≥ 16.
- `FRAME_CNT_W`, 8: width of the committed-frame counter.

- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  reset; one clock domain; synchronous, active-high.
- `write_en`  in  1  write one byte this cycle.
- `data_in`  in  DATA_WIDTH  byte to write.
- `wr_last`  in  1  qualifies `write_en`; byte is the final byte of the frame.
- `wr_err`  in  1  qualifies `write_en && wr_last`; frame is bad (FCS/length error), drop it.
- `read_en`  in  1  pop one byte; ignored when `empty`.
- `data_out`  out  DATA_WIDTH  popped byte.
- `rd_valid`  out  1  `data_out`/`rd_last` are valid this cycle.
- `rd_last`  out  1  popped byte is the final byte of its frame.
- `empty`  out  1  no committed bytes available.
- `full`  out  1  no free entry for a speculative write.
- `frame_avail`  out  1  at least one complete committed frame is unread.
- `frame_drop`  out  1  one-cycle pulse when a frame is discarded.

## Operation
- Storage: `FIFO_DEPTH` × (`DATA_WIDTH`+1) entries; the extra bit holds the last flag.
- Pointers are `$clog2(FIFO_DEPTH)+1` bits wide, with a wrap bit, and increment modulo 2·`FIFO_DEPTH`. There are three: `wr_ptr` (speculative), `cm_ptr` (committed end), `rd_ptr`.
- `full` = (`wr_ptr` − `rd_ptr`) == `FIFO_DEPTH`. `empty` = `rd_ptr` == `cm_ptr`.
- Write state machine, states ACCEPT and DISCARD:
  - ACCEPT, `write_en` && !`full`: store {`wr_last`, `data_in`} at `wr_ptr`, then `wr_ptr`++.
    - If `wr_last` && !`wr_err`: `cm_ptr` ← new `wr_ptr`, frame counter +1.
    - If `wr_last` && `wr_err`: `wr_ptr` ← `cm_ptr`, pulse `frame_drop`, nothing is stored.
  - ACCEPT, `write_en` && `full`: overflow. If `wr_last`, rewind `wr_ptr` ← `cm_ptr` and pulse `frame_drop`. Otherwise go to DISCARD.
  - DISCARD: all writes are ignored. On `write_en && wr_last`, rewind `wr_ptr` ← `cm_ptr`, pulse `frame_drop`, go to ACCEPT.
- A frame larger than `FIFO_DEPTH` always ends in a drop. Committed data is never corrupted by a drop.
- Read: `read_en && !empty` reads the entry at `rd_ptr`, then `rd_ptr`++. A popped byte with last=1 decrements the frame counter.
- `frame_avail` = frame counter ≠ 0.
- Commit and last-byte pop in the same cycle leave the counter unchanged. The counter saturates at its maximum and never underflows.

## Timing
- Reset values: `data_out`=0, `rd_valid`=0, `rd_last`=0, `empty`=1, `full`=0, `frame_avail`=0, `frame_drop`=0. All pointers and the counter are 0, and the state machine is in ACCEPT. Memory contents are not reset.
- Read latency is 1 cycle: `read_en` accepted at edge N gives `rd_valid`, `data_out` and `rd_last` after edge N+1.
- Back-to-back reads sustain 1 byte per clock.
- Commit-to-visibility is 1 cycle: the commit write at edge N drops `empty` and raises `frame_avail` after edge N+1.
- `full`, `empty` and `frame_avail` are registered or derived from registers only; there is no combinational path from inputs.
- Simultaneous write and read are always allowed, including at `full` and `empty`, each judged on pre-edge flags.
- `rst` asserted mid-frame or mid-read clears everything on that edge. A partially written frame is lost without a `frame_drop` pulse.

## Structure
- Shared package `eth_mac_pkg` holds the default `FIFO_DEPTH`, `DATA_WIDTH`, and the write-state enum {ACCEPT, DISCARD}.
- One sub-module, `fifo_rx_mem`: a simple dual-port RAM with a registered read port, inferable as block RAM.
- Pointer logic, the write state machine and the frame counter stay in `fifo_rx`.

## Test plan
- **Single good frame:** write 0xAA, 0xBB, 0xCC (last on 0xCC) → `frame_avail`=1 one cycle later. Three reads return AA, BB, CC with `rd_last` only on CC, after which `empty`=1 and `frame_avail`=0.
- **Errored frame after good frame:** good frame 0x11, 0x22 then bad frame 0x33, 0x44 (`wr_err` on 0x44) → one `frame_drop` pulse. Reads return only 11, 22 and `wr_ptr` equals `cm_ptr`.
- **Overflow (DEPTH=16):** 20-byte frame → `full` after byte 16, DISCARD until last, `frame_drop` on the last byte. The FIFO stays empty and a following 4-byte frame is received intact.
- **Wrap-around:** ten 5-byte frames written and read interleaved (crossing pointer wrap) → every byte and `rd_last` position matches, with no spurious `full` or `empty`.
- **Simultaneous events:** commit of frame 2 in the same cycle as the `rd_last` pop of frame 1 → frame counter stays 1 and `frame_avail` stays 1.
- **Reset mid-operation:** `rst` while frame 1 is half read and frame 2 is half written → next cycle `empty`=1, `frame_avail`=0, `rd_valid`=0, no `frame_drop`. A new frame after reset is received correctly.

Source files
------------

// File: rtl/eth_mac_pkg.sv
// Shared definitions for the Ethernet MAC buffers: default geometry and the
// receive FIFO write-side state encoding.
package eth_mac_pkg;

    localparam int DATA_WIDTH_DEF  = 8;
    localparam int FIFO_DEPTH_DEF  = 2048;
    localparam int FRAME_CNT_W_DEF = 8;

    // ACCEPT stores bytes speculatively; DISCARD swallows the rest of an
    // overflowing frame until its last byte arrives.
    typedef enum logic {
        ACCEPT  = 1'b0,
        DISCARD = 1'b1
    } wr_state_e;

endpackage

// File: rtl/fifo_rx_if.sv
// Receive FIFO bus: MAC write side, host read side and status flags.
// master = the environment driving the FIFO, slave = the FIFO itself.
interface fifo_rx_if
    import eth_mac_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
) ();

    logic                  write_en;
    logic [DATA_WIDTH-1:0] data_in;
    logic                  wr_last;
    logic                  wr_err;
    logic                  read_en;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  rd_valid;
    logic                  rd_last;
    logic                  empty;
    logic                  full;
    logic                  frame_avail;
    logic                  frame_drop;

    modport master (
        output write_en, data_in, wr_last, wr_err, read_en,
        input  data_out, rd_valid, rd_last, empty, full, frame_avail, frame_drop
    );

    modport slave (
        input  write_en, data_in, wr_last, wr_err, read_en,
        output data_out, rd_valid, rd_last, empty, full, frame_avail, frame_drop
    );

endinterface

// File: rtl/fifo_rx_mem.sv
// Simple dual-port RAM with a registered read port (block-RAM style).
// Only the output register is reset; the array itself is never cleared.
module fifo_rx_mem #(
    parameter  int WIDTH = 9,
    parameter  int DEPTH = 2048,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Write port.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
    end

    // Registered read port; holds its value between reads.
    always_ff @(posedge clk) begin
        if (rst)        rd_data <= '0;
        else if (rd_en) rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/fifo_rx.sv
// Frame-aware receive FIFO. Bytes are written speculatively at wr_ptr and only
// become readable once the frame commits (cm_ptr advances). Bad or overflowing
// frames are dropped by rewinding wr_ptr to cm_ptr.
module fifo_rx
    import eth_mac_pkg::*;
#(
    parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
    parameter int FIFO_DEPTH  = FIFO_DEPTH_DEF,
    parameter int FRAME_CNT_W = FRAME_CNT_W_DEF
) (
    input  logic      clk,
    input  logic      rst,
    fifo_rx_if.slave  bus
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = AW + 1;
    localparam logic [FRAME_CNT_W-1:0] CNT_MAX = '1;

    logic [PW-1:0]          wr_ptr, cm_ptr, rd_ptr;
    logic [PW-1:0]          wr_ptr_inc, used;
    wr_state_e              state;
    logic [FRAME_CNT_W-1:0] frame_cnt;
    logic                   full_w, empty_w;
    logic                   wr_fire, mem_wr, commit, rd_fire;
    logic                   rd_valid_q, frame_drop_q, pop_last;
    logic [DATA_WIDTH:0]    rd_word;

    assign used       = wr_ptr - rd_ptr;
    assign full_w     = (used == PW'(FIFO_DEPTH));
    assign empty_w    = (rd_ptr == cm_ptr);
    assign wr_ptr_inc = wr_ptr + 1'b1;

    // Flags are judged on pre-edge pointer state, so write and read can
    // both proceed in the same cycle at full or empty.
    assign wr_fire  = (state == ACCEPT) && bus.write_en && !full_w;
    assign mem_wr   = wr_fire && !(bus.wr_last && bus.wr_err);
    assign commit   = mem_wr && bus.wr_last;
    assign rd_fire  = bus.read_en && !empty_w;
    // The last flag of a popped byte is only known once it leaves the RAM.
    assign pop_last = rd_valid_q && rd_word[DATA_WIDTH];

    fifo_rx_mem #(
        .WIDTH (DATA_WIDTH + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_mem (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (mem_wr),
        .wr_addr (wr_ptr[AW-1:0]),
        .wr_data ({bus.wr_last, bus.data_in}),
        .rd_en   (rd_fire),
        .rd_addr (rd_ptr[AW-1:0]),
        .rd_data (rd_word)
    );

    // Write state machine: speculative write pointer, commit pointer, drop pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ACCEPT;
            wr_ptr       <= '0;
            cm_ptr       <= '0;
            frame_drop_q <= 1'b0;
        end else begin
            frame_drop_q <= 1'b0;
            case (state)
                ACCEPT: begin
                    if (bus.write_en) begin
                        if (!full_w) begin
                            if (bus.wr_last && bus.wr_err) begin
                                wr_ptr       <= cm_ptr;
                                frame_drop_q <= 1'b1;
                            end else begin
                                wr_ptr <= wr_ptr_inc;
                                if (bus.wr_last) cm_ptr <= wr_ptr_inc;
                            end
                        end else if (bus.wr_last) begin
                            wr_ptr       <= cm_ptr;
                            frame_drop_q <= 1'b1;
                        end else begin
                            state <= DISCARD;
                        end
                    end
                end
                DISCARD: begin
                    if (bus.write_en && bus.wr_last) begin
                        wr_ptr       <= cm_ptr;
                        frame_drop_q <= 1'b1;
                        state        <= ACCEPT;
                    end
                end
                default: state <= ACCEPT;
            endcase
        end
    end

    // Read pointer and output-valid tracking.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr     <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= rd_fire;
            if (rd_fire) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Committed-frame counter: saturates high, never underflows, and a
    // commit coinciding with a last-byte pop leaves it unchanged.
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_cnt <= '0;
        end else if (commit && !pop_last) begin
            if (frame_cnt != CNT_MAX) frame_cnt <= frame_cnt + 1'b1;
        end else if (!commit && pop_last) begin
            if (frame_cnt != '0) frame_cnt <= frame_cnt - 1'b1;
        end
    end

    assign bus.data_out    = rd_word[DATA_WIDTH-1:0];
    assign bus.rd_last     = rd_word[DATA_WIDTH];
    assign bus.rd_valid    = rd_valid_q;
    assign bus.empty       = empty_w;
    assign bus.full        = full_w;
    assign bus.frame_avail = (frame_cnt != '0);
    assign bus.frame_drop  = frame_drop_q;

endmodule
